fetch_unit: RTL and testbench

//   Instruction fetch stage feeding the decoder: owns the PC and issues sequential word requests to imem.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential word requests to imem and
// buffers in-order responses for decode; a redirect flushes buffered and in-flight fetches.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]   pq_head_q, pq_head_d, pq_tail_q, pq_tail_d;

  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] pq_q        [DEPTH];

  logic          req_fire, resp_fire, resp_keep, pop;
  logic [CW:0]   slots_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The slot being popped this cycle counts as free, which keeps one fetch per cycle
  // in steady state; the request gate then depends combinationally on inst_ready.
  assign pop        = inst_valid && inst_ready;
  assign slots_used = {1'b0, inflight_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};

  assign imem_req_valid = rst_n && !redirect_valid && (slots_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = imem_resp_valid && (inflight_q != '0);
  assign resp_keep      = resp_fire && (drop_q == '0) && !redirect_valid;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? fifo_data_q[head_q] : NOP;
  assign inst_pc    = inst_valid ? fifo_pc_q[head_q] : '0;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pq_head_d  = pq_head_q;
    pq_tail_d  = pq_tail_q;

    if (req_fire)  pq_tail_d = ptr_inc(pq_tail_q);
    if (resp_fire) pq_head_d = ptr_inc(pq_head_q);

    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      pc_d    = redirect_pc & ~XLEN'(3);
      drop_d  = inflight_d;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (resp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (resp_keep) tail_d = ptr_inc(tail_q);
      if (pop)       head_d = ptr_inc(head_q);
      count_d = count_q + CW'(resp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pq_head_q  <= '0;
      pq_tail_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pq_head_q  <= pq_head_d;
      pq_tail_q  <= pq_tail_d;
    end
  end

  // NOTE: storage arrays are not reset; the counters and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (req_fire) pq_q[pq_tail_q] <= pc_q;
    if (resp_keep) begin
      fifo_data_q[tail_q] <= imem_resp_data;
      fifo_pc_q[tail_q]   <= pq_q[pq_head_q];
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (inflight_q == '0)));
  a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= inflight_q);
  a_credit_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, inflight_q} + {1'b0, count_q}) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: small in-order imem model with optional response hold,
// one task per scenario, each comparing against hand-derived values.
module tb_fetch_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid, inst_ready;
  logic [XLEN-1:0] inst, inst_pc;

  logic            resp_hold;
  logic            pend_v;
  logic [XLEN-1:0] pend_a;
  logic [XLEN-1:0] pend_q [$];

  int total = 0;
  int bad = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // imem: 1-cycle in-order latency, data = addr ^ KEY, responses held while resp_hold=1
  assign imem_resp_valid = pend_v && !resp_hold;
  assign imem_resp_data  = pend_a ^ KEY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      pend_v <= 1'b0;
      pend_a <= '0;
    end else begin
      if (imem_resp_valid) void'(pend_q.pop_front());
      if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      pend_v <= (pend_q.size() != 0);
      pend_a <= (pend_q.size() != 0) ? pend_q[0] : '0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_hold      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; resp_hold = 1'b0;
    step();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    total++; if (inst !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", inst, NOP); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_req_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL s1_c0 got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    step();
    total++; if (imem_req_addr !== 32'h4 || inst_valid !== 1'b0) begin bad++; $display("FAIL s1_c1 got=%h/%b exp=4/0", imem_req_addr, inst_valid); end
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL s1_c2_req got=%b/%h exp=1/8", imem_req_valid, imem_req_addr); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== KEY) begin bad++; $display("FAIL s1_c2_inst got=%b/%h/%h exp=1/0/%h", inst_valid, inst_pc, inst, KEY); end
    step();
    total++; if (imem_req_addr !== 32'hC || inst_pc !== 32'h4 || inst !== (KEY ^ 32'h4)) begin bad++; $display("FAIL s1_c3 got=%h/%h/%h exp=c/4/%h", imem_req_addr, inst_pc, inst, KEY ^ 32'h4); end
    step();
    total++; if (inst_pc !== 32'h8 || imem_req_addr !== 32'h10) begin bad++; $display("FAIL s1_c4 got=%h/%h exp=8/10", inst_pc, imem_req_addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    step();
    step();
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL s2_c2 got=%b/%h exp=0/8", imem_req_valid, imem_req_addr); end
    step();
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL s2_c3 got=%b/%b/%h exp=0/1/0", imem_req_valid, inst_valid, inst_pc); end
    inst_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL s2_resume got=%b/%h exp=1/8", imem_req_valid, imem_req_addr); end
    step();
    total++; if (inst_pc !== 32'h4 || imem_req_addr !== 32'hC) begin bad++; $display("FAIL s2_c4 got=%h/%h exp=4/c", inst_pc, imem_req_addr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL s3_hold%0d got=%b/%h exp=1/4", i, imem_req_valid, imem_req_addr); end
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    total++; if (imem_req_addr !== 32'h4) begin bad++; $display("FAIL s3_c4 got=%h exp=4", imem_req_addr); end
    step();
    total++; if (imem_req_addr !== 32'h8) begin bad++; $display("FAIL s3_c5 got=%h exp=8", imem_req_addr); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin bad++; $display("FAIL s3_c6 got=%b/%h exp=1/4", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    resp_hold = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL s4_c2 got=%b exp=0", imem_req_valid); end
    step();
    redirect_valid = 1'b0; resp_hold = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin bad++; $display("FAIL s4_c3 got=%b/%h/%b exp=0/100/0", imem_req_valid, imem_req_addr, inst_valid); end
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin bad++; $display("FAIL s4_c4 got=%b/%h/%b exp=1/100/0", imem_req_valid, imem_req_addr, inst_valid); end
    step();
    total++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h104) begin bad++; $display("FAIL s4_c5 got=%b/%h exp=0/104", inst_valid, imem_req_addr); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== (KEY ^ 32'h100)) begin bad++; $display("FAIL s4_c6 got=%b/%h/%h exp=1/100/%h", inst_valid, inst_pc, inst, KEY ^ 32'h100); end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_resp_valid !== 1'b1 || inst_valid !== 1'b1) begin bad++; $display("FAIL s5_setup got=%b/%b/%b exp=0/1/1", imem_req_valid, imem_resp_valid, inst_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0) begin bad++; $display("FAIL s5_c3_fifo got=%b/%h/%h exp=0/%h/0", inst_valid, inst, inst_pc, NOP); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("FAIL s5_c3_req got=%b/%h exp=1/200", imem_req_valid, imem_req_addr); end
    step();
    total++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h204) begin bad++; $display("FAIL s5_c4 got=%b/%h exp=0/204", inst_valid, imem_req_addr); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin bad++; $display("FAIL s5_c5 got=%b/%h exp=1/200", inst_valid, inst_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    resp_hold = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0; resp_hold = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h80) begin bad++; $display("FAIL b2b_c4 got=%b/%h exp=0/80", imem_req_valid, imem_req_addr); end
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_c5 got=%b/%h/%b exp=1/80/0", imem_req_valid, imem_req_addr, inst_valid); end
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_c6 got=%b exp=0", inst_valid); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) begin bad++; $display("FAIL b2b_c7 got=%b/%h exp=1/80", inst_valid, inst_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    step();
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin bad++; $display("FAIL s6_pre got=%b/%h exp=1/4", inst_valid, inst_pc); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0) begin bad++; $display("FAIL s6_fifo got=%b/%h/%h exp=0/%h/0", inst_valid, inst, inst_pc, NOP); end
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL s6_req got=%b/%h exp=0/0", imem_req_valid, imem_req_addr); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL s6_restart got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    step();
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL s6_post got=%b/%h exp=1/0", inst_valid, inst_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
